plic_target: RTL and testbench

PLIC_TARGET -- requirements
Module: plic_target

---
 rtl/plic_pkg.sv | 14 +
 rtl/plic_prio_tree.sv | 27 ++
 rtl/plic_target.sv | 132 +++++++++++++
 tb/tb_plic_target.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plic_pkg.sv
// Shared defaults and claim FSM state type for the PLIC target slice.
package plic_pkg;

    localparam int N_SRC_DEF  = 31;
    localparam int PRIO_W_DEF = 3;
    localparam int ID_W_DEF   = $clog2(N_SRC_DEF + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESP   = 2'd1,
        ST_SETTLE = 2'd2
    } claim_state_e;

endpackage

// File: rtl/plic_prio_tree.sv
// Combinational selector: highest-priority eligible source, lowest ID on ties.
module plic_prio_tree
    import plic_pkg::*;
#(
    parameter int N_SRC  = N_SRC_DEF,
    parameter int PRIO_W = PRIO_W_DEF,
    parameter int ID_W   = ID_W_DEF
) (
    input  logic [N_SRC-1:0]        elig,
    input  logic [N_SRC*PRIO_W-1:0] prio,
    output logic [ID_W-1:0]         best_id,
    output logic [PRIO_W-1:0]       best_prio
);

    // Strict '>' while scanning upward keeps the lowest ID among equal priorities.
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (elig[k] && (prio[k*PRIO_W +: PRIO_W] > best_prio)) begin
                best_id   = ID_W'(k + 1);
                best_prio = prio[k*PRIO_W +: PRIO_W];
            end
        end
    end

endmodule

// File: rtl/plic_target.sv
// PLIC target: pending bits, registered arbiter, threshold irq, claim FSM and completion routing.
//   state     | meaning
//   ST_IDLE   | ready for a claim; claim_i captures the winning ID
//   ST_RESP   | claim_vld_o pulse with the captured ID
//   ST_SETTLE | one cycle for the arbiter to see the cleared pending bit
module plic_target
    import plic_pkg::*;
#(
    parameter  int N_SRC  = N_SRC_DEF,
    parameter  int PRIO_W = PRIO_W_DEF,
    localparam int ID_W   = $clog2(N_SRC + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_SRC-1:0]        valid_i,
    output logic [N_SRC-1:0]        ready_o,
    output logic [N_SRC-1:0]        comp_o,
    input  logic [N_SRC*PRIO_W-1:0] prio_i,
    input  logic [N_SRC-1:0]        ie_i,
    input  logic [PRIO_W-1:0]       thold_i,
    input  logic                    claim_i,
    output logic                    claim_rdy_o,
    output logic                    claim_vld_o,
    output logic [ID_W-1:0]         claim_id_o,
    input  logic                    compl_i,
    input  logic [ID_W-1:0]         compl_id_i,
    output logic                    irq_o,
    output logic [N_SRC-1:0]        pend_o
);

    logic [N_SRC-1:0]  pend_q;
    logic [N_SRC-1:0]  elig;
    logic [N_SRC-1:0]  clr_mask;
    logic [N_SRC-1:0]  comp_d;
    logic [N_SRC-1:0]  comp_q;
    logic [ID_W-1:0]   best_id_d;
    logic [ID_W-1:0]   best_id_q;
    logic [PRIO_W-1:0] best_prio_d;
    logic [PRIO_W-1:0] best_prio_q;
    logic [ID_W-1:0]   cap_id;
    logic [ID_W-1:0]   claim_id_q;
    logic              irq_q;
    logic              claim_take;
    claim_state_e      state_q;
    claim_state_e      state_d;

    assign ready_o = valid_i & ~pend_q;
    assign pend_o  = pend_q;

    always_comb begin
        elig = '0;
        for (int k = 0; k < N_SRC; k++) begin
            elig[k] = pend_q[k] & ie_i[k] & (prio_i[k*PRIO_W +: PRIO_W] != '0);
        end
    end

    plic_prio_tree #(
        .N_SRC  (N_SRC),
        .PRIO_W (PRIO_W),
        .ID_W   (ID_W)
    ) u_prio_tree (
        .elig      (elig),
        .prio      (prio_i),
        .best_id   (best_id_d),
        .best_prio (best_prio_d)
    );

    assign cap_id = (best_prio_q > thold_i) ? best_id_q : '0;

    // One-hot decodes; IDs outside 1..N_SRC match no bit and are dropped.
    always_comb begin
        clr_mask = '0;
        comp_d   = '0;
        for (int k = 0; k < N_SRC; k++) begin
            clr_mask[k] = claim_take & (cap_id == ID_W'(k + 1));
            comp_d[k]   = compl_i & ie_i[k] & (compl_id_i == ID_W'(k + 1));
        end
    end

    always_comb begin
        state_d    = state_q;
        claim_take = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (claim_i) begin
                    claim_take = 1'b1;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP:   state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Claim clear is applied after the set so it wins on a same-cycle collision.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q      <= '0;
            best_id_q   <= '0;
            best_prio_q <= '0;
            irq_q       <= 1'b0;
            claim_id_q  <= '0;
            comp_q      <= '0;
        end else begin
            pend_q      <= (pend_q | ready_o) & ~clr_mask;
            best_id_q   <= best_id_d;
            best_prio_q <= best_prio_d;
            irq_q       <= best_prio_q > thold_i;
            comp_q      <= comp_d;
            if (claim_take) begin
                claim_id_q <= cap_id;
            end
        end
    end

    // Gated by rst_i so a reset landing in RESP suppresses the pulse.
    assign claim_vld_o = (state_q == ST_RESP) & ~rst_i;
    assign claim_rdy_o = (state_q == ST_IDLE);
    assign claim_id_o  = claim_id_q;
    assign comp_o      = comp_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_plic_target.sv
// Bench for plic_target: directed sequences, a completion table, then random traffic vs a reference model.
module tb_plic_target;

    // 30 sources leave ID 31 representable but out of range.
    localparam int N   = 30;
    localparam int PW  = 3;
    localparam int IDW = $clog2(N + 1);

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic [N-1:0]    valid_i = '0;
    logic [N-1:0]    ready_o;
    logic [N-1:0]    comp_o;
    logic [N*PW-1:0] prio_i = '0;
    logic [N-1:0]    ie_i = '0;
    logic [PW-1:0]   thold_i = '0;
    logic            claim_i = 1'b0;
    logic            claim_rdy_o;
    logic            claim_vld_o;
    logic [IDW-1:0]  claim_id_o;
    logic            compl_i = 1'b0;
    logic [IDW-1:0]  compl_id_i = '0;
    logic            irq_o;
    logic [N-1:0]    pend_o;

    int n_total = 0;
    int n_bad   = 0;

    // reference model state
    logic [N-1:0] m_pend = '0;
    logic [N-1:0] m_comp = '0;
    int           m_bid = 0;
    int           m_bp = 0;
    logic         m_irq = 1'b0;
    int           m_busy = 0;
    int           m_cid = 0;

    plic_target #(.N_SRC(N), .PRIO_W(PW)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .comp_o      (comp_o),
        .prio_i      (prio_i),
        .ie_i        (ie_i),
        .thold_i     (thold_i),
        .claim_i     (claim_i),
        .claim_rdy_o (claim_rdy_o),
        .claim_vld_o (claim_vld_o),
        .claim_id_o  (claim_id_o),
        .compl_i     (compl_i),
        .compl_id_i  (compl_id_i),
        .irq_o       (irq_o),
        .pend_o      (pend_o)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int prio_of(input int k);
        return int'(prio_i[(k-1)*PW +: PW]);
    endfunction

    // Max priority first, then the smallest ID holding it.
    task automatic arb(input logic [N-1:0] e, output int id, output int p);
        int mx;
        mx = 0;
        id = 0;
        for (int k = 1; k <= N; k++)
            if (e[k-1] && prio_of(k) > mx) mx = prio_of(k);
        p = mx;
        if (mx != 0)
            for (int k = N; k >= 1; k--)
                if (e[k-1] && prio_of(k) == mx) id = k;
    endtask

    task automatic model_edge();
        logic [N-1:0] rdy;
        logic [N-1:0] clr;
        logic [N-1:0] cmp;
        int bid, bp, cid, ci;
        if (rst_i) begin
            m_pend = '0; m_comp = '0; m_bid = 0; m_bp = 0;
            m_irq = 1'b0; m_busy = 0; m_cid = 0;
            return;
        end
        rdy = valid_i & ~m_pend;
        arb(m_pend & ie_i, bid, bp);
        clr = '0;
        if (m_busy == 0 && claim_i) begin
            cid = (m_bp > int'(thold_i)) ? m_bid : 0;
            if (cid != 0) clr[cid-1] = 1'b1;
            m_cid  = cid;
            m_busy = 2;
        end else if (m_busy > 0) begin
            m_busy--;
        end
        cmp = '0;
        ci = int'(compl_id_i);
        if (compl_i && ci >= 1 && ci <= N && ie_i[ci-1]) cmp[ci-1] = 1'b1;
        m_irq  = (m_bp > int'(thold_i));
        m_bid  = bid;
        m_bp   = bp;
        m_comp = cmp;
        m_pend = (m_pend | rdy) & ~clr;
    endtask

    task automatic model_check();
        chk("ready", 32'(ready_o), 32'(valid_i & ~m_pend));
        chk("claim_rdy", 32'(claim_rdy_o), 32'(m_busy == 0));
        chk("claim_vld", 32'(claim_vld_o), 32'(m_busy == 2 && !rst_i));
        chk("claim_id", 32'(claim_id_o), 32'(m_cid));
        chk("irq", 32'(irq_o), 32'(m_irq));
        chk("pend", 32'(pend_o), 32'(m_pend));
        chk("comp", 32'(comp_o), 32'(m_comp));
    endtask

    // Called at posedge+1; checks mid-cycle, then advances one edge.
    task automatic cycle();
        #4;
        model_check();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_prio(input int k, input int p);
        prio_i[(k-1)*PW +: PW] = PW'(p);
    endtask

    task automatic do_reset();
        valid_i = '0; claim_i = 1'b0; compl_i = 1'b0; compl_id_i = '0;
        prio_i = '0; ie_i = '1; thold_i = '0;
        rst_i = 1'b1;
        cycle();
        cycle();
        rst_i = 1'b0;
    endtask

    task automatic do_claim(input string name, input int exp);
        claim_i = 1'b1;
        cycle();
        claim_i = 1'b0;
        chk({name, "_vld"}, 32'(claim_vld_o), 32'd1);
        chk(name, 32'(claim_id_o), 32'(exp));
        cycle();
        cycle();
    endtask

    typedef struct {
        int          id;
        bit          ie4;
        logic [31:0] exp;
    } comp_vec_t;

    comp_vec_t cvec[6];

    initial begin
        cvec[0] = '{4,  1'b1, 32'h0000_0008};
        cvec[1] = '{0,  1'b1, 32'h0000_0000};
        cvec[2] = '{31, 1'b1, 32'h0000_0000};
        cvec[3] = '{4,  1'b0, 32'h0000_0000};
        cvec[4] = '{30, 1'b1, 32'h2000_0000};
        cvec[5] = '{1,  1'b1, 32'h0000_0001};

        // First edge primes the DUT out of X before any comparison.
        @(posedge clk);
        model_edge();
        #1;
        do_reset();
        chk("rst_irq", 32'(irq_o), 32'd0);
        chk("rst_pend", 32'(pend_o), 32'd0);
        chk("rst_claim_id", 32'(claim_id_o), 32'd0);
        chk("rst_claim_rdy", 32'(claim_rdy_o), 32'd1);

        // single source, latency of irq, claim drops irq
        set_prio(5, 3);
        valid_i[4] = 1'b1;
        #1 chk("ready5", 32'(ready_o[4]), 32'd1);
        cycle();
        valid_i = '0;
        chk("irq_lat0", 32'(irq_o), 32'd0);
        cycle();
        chk("irq_lat1", 32'(irq_o), 32'd0);
        cycle();
        chk("irq_lat2", 32'(irq_o), 32'd1);
        do_claim("claim5", 5);
        chk("irq_after_claim", 32'(irq_o), 32'd0);

        // tie-break and ordering
        do_reset();
        set_prio(3, 2); set_prio(7, 2); set_prio(9, 1);
        valid_i[2] = 1'b1; valid_i[6] = 1'b1; valid_i[8] = 1'b1;
        cycle();
        valid_i = '0;
        cycle();
        do_claim("order_a", 3);
        do_claim("order_b", 7);
        do_claim("order_c", 9);
        do_claim("order_empty", 0);

        // threshold boundary
        do_reset();
        set_prio(4, 2); thold_i = 3'd2;
        valid_i[3] = 1'b1;
        cycle();
        valid_i = '0;
        cycle();
        cycle();
        chk("thold_eq_irq", 32'(irq_o), 32'd0);
        do_claim("thold_eq_claim", 0);
        thold_i = 3'd1;
        cycle();
        chk("thold_lt_irq", 32'(irq_o), 32'd1);
        do_claim("thold_lt_claim", 4);

        // completion routing table
        do_reset();
        foreach (cvec[i]) begin
            ie_i = '1;
            ie_i[3] = cvec[i].ie4;
            compl_i = 1'b1;
            compl_id_i = IDW'(cvec[i].id);
            cycle();
            compl_i = 1'b0;
            chk($sformatf("comp_vec%0d", i), 32'(comp_o), cvec[i].exp);
            cycle();
            chk($sformatf("comp_vec%0d_off", i), 32'(comp_o), 32'd0);
        end

        // back-to-back claims
        do_reset();
        set_prio(3, 2); set_prio(7, 2);
        valid_i[2] = 1'b1; valid_i[6] = 1'b1;
        cycle();
        valid_i = '0;
        cycle();
        claim_i = 1'b1;
        cycle();
        chk("b2b_id", 32'(claim_id_o), 32'd3);
        chk("b2b_rdy0", 32'(claim_rdy_o), 32'd0);
        cycle();
        claim_i = 1'b0;
        chk("b2b_rdy1", 32'(claim_rdy_o), 32'd0);
        cycle();
        chk("b2b_rdy2", 32'(claim_rdy_o), 32'd1);
        chk("b2b_pend7", 32'(pend_o[6]), 32'd1);

        // claim and completion together
        claim_i = 1'b1; compl_i = 1'b1; compl_id_i = IDW'(2);
        cycle();
        claim_i = 1'b0; compl_i = 1'b0;
        chk("both_vld", 32'(claim_vld_o), 32'd1);
        chk("both_id", 32'(claim_id_o), 32'd7);
        chk("both_comp", 32'(comp_o), 32'h2);
        cycle();
        cycle();

        // reset during RESP
        do_reset();
        set_prio(9, 2);
        valid_i[8] = 1'b1;
        cycle();
        valid_i = '0;
        cycle();
        claim_i = 1'b1;
        cycle();
        claim_i = 1'b0;
        rst_i = 1'b1;
        #1 chk("rst_resp_vld", 32'(claim_vld_o), 32'd0);
        cycle();
        rst_i = 1'b0;
        chk("rst_resp_vld2", 32'(claim_vld_o), 32'd0);
        chk("rst_resp_id", 32'(claim_id_o), 32'd0);
        chk("rst_resp_pend", 32'(pend_o), 32'd0);
        chk("rst_resp_irq", 32'(irq_o), 32'd0);
        chk("rst_resp_rdy", 32'(claim_rdy_o), 32'd1);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            if (c % 40 == 0) begin
                for (int k = 1; k <= N; k++) set_prio(k, $urandom_range(0, 7));
                ie_i = N'($urandom | $urandom);
                thold_i = PW'($urandom_range(0, 3));
            end
            valid_i    = N'($urandom & $urandom & $urandom);
            claim_i    = ($urandom_range(0, 3) == 0);
            compl_i    = ($urandom_range(0, 3) == 0);
            compl_id_i = IDW'($urandom_range(0, 31));
            rst_i      = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst_i = 1'b0;
        cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
